// File: rtl/uart_dbg_pkg.sv
// Shared constants, FSM state type and byte-select helper for the register-dump UART path.
// The ST_CHKSUM state only exists when DUMP_CHECKSUM_EN is defined.
package uart_dbg_pkg;

    localparam logic [7:0] DUMP_SYNC_BYTE = 8'hA5;
    localparam int         NUM_DBG_REGS   = 32;
    localparam int         BYTES_PER_REG  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WORD,
`ifdef DUMP_CHECKSUM_EN
        ST_CHKSUM,
`endif
        ST_FINISH
    } dump_state_e;

    // Little-endian byte select: idx 0 is bits 7:0.
    function automatic logic [7:0] reg_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serialiser: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// ready is high while idle and in the last cycle of the stop bit, so bytes chain with no gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_DATA = 4'd8;
    localparam logic [3:0]       STOP_BIT  = 4'd9;

    logic             active_q, active_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (baud_cnt_q == BAUD_LAST);
    assign ready   = !active_q || (bit_end && (bit_idx_q == STOP_BIT));
    assign tx      = tx_q;

    always_comb begin
        active_d   = active_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        if (valid && ready) begin
            active_d   = 1'b1;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            shift_d    = data;
            tx_d       = 1'b0;
        end else if (active_q) begin
            if (!bit_end) begin
                baud_cnt_d = baud_cnt_q + CNT_W'(1);
            end else begin
                baud_cnt_d = '0;
                if (bit_idx_q == STOP_BIT) begin
                    active_d  = 1'b0;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == LAST_DATA) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            active_q   <= active_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: rtl/reg_dump_uart_tx.sv
// Serialises x0..x31 from the debug register bus as one framed UART dump (sync byte, then 4 LE bytes per register).
// Define DUMP_CHECKSUM_EN to append an XOR checksum byte over the 128 payload bytes.
module reg_dump_uart_tx
    import uart_dbg_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dbg_regs [0:NUM_DBG_REGS-1],
    input  logic        dump_req,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int               CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int               REG_W        = $clog2(NUM_DBG_REGS);
    localparam logic [REG_W-1:0] LAST_REG     = REG_W'(NUM_DBG_REGS - 1);
    localparam logic [1:0]       LAST_BYTE    = 2'(BYTES_PER_REG - 1);

    dump_state_e      state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [REG_W-1:0] reg_idx_q, reg_idx_d;
    logic [31:0]      hold_q, hold_d;
    logic [1:0]       byte_next;
    logic [REG_W-1:0] reg_next;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    assign byte_next = byte_idx_q + 2'd1;
    assign reg_next  = reg_idx_q + REG_W'(1);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done      = (state_q == ST_FINISH);

    // Byte 0 of each word goes straight from the bus while the whole word is captured for bytes 1..3.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        reg_idx_d  = reg_idx_q;
        hold_d     = hold_q;
        byte_valid = 1'b0;
        byte_data  = DUMP_SYNC_BYTE;
        case (state_q)
            ST_IDLE: begin
                if (dump_req && byte_ready) begin
                    byte_valid = 1'b1;
                    byte_idx_d = '0;
                    reg_idx_d  = '0;
                    state_d    = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (byte_ready) begin
                    byte_valid = 1'b1;
                    byte_data  = reg_byte(dbg_regs[0], 2'd0);
                    hold_d     = dbg_regs[0];
                    byte_idx_d = '0;
                    reg_idx_d  = '0;
                    state_d    = ST_WORD;
                end
            end
            ST_WORD: begin
                if (byte_ready) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_valid = 1'b1;
                        byte_data  = reg_byte(hold_q, byte_next);
                        byte_idx_d = byte_next;
                    end else if (reg_idx_q != LAST_REG) begin
                        byte_valid = 1'b1;
                        byte_data  = reg_byte(dbg_regs[reg_next], 2'd0);
                        hold_d     = dbg_regs[reg_next];
                        byte_idx_d = '0;
                        reg_idx_d  = reg_next;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        byte_valid = 1'b1;
                        byte_data  = chk_q;
                        state_d    = ST_CHKSUM;
`else
                        state_d    = ST_FINISH;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CHKSUM: begin
                if (byte_ready) begin
                    state_d = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DUMP_CHECKSUM_EN
    // Every payload byte is loaded on a transition that stays in or enters ST_WORD.
    always_comb begin
        chk_d = chk_q;
        if (state_q == ST_IDLE) begin
            chk_d = '0;
        end else if (byte_valid && (state_d == ST_WORD)) begin
            chk_d = chk_q ^ byte_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            reg_idx_q  <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            reg_idx_q  <= reg_idx_d;
            hold_q     <= hold_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst_n(reset),
        .data (byte_data),
        .valid(byte_valid),
        .ready(byte_ready),
        .tx   (uart_tx)
    );

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Self-checking bench for reg_dump_uart_tx: a frame-timeline model checked every cycle plus a UART receiver for literal byte checks.
// Define DUMP_CHECKSUM_EN to expect the 130-byte frame with trailing checksum.
module tb_reg_dump_uart_tx;

    localparam int CLK_FREQ_HZ = 160;
    localparam int BAUD        = 10;
    localparam int CPB         = 16;
    localparam int BYTE_CYC    = 10 * CPB;
`ifdef DUMP_CHECKSUM_EN
    localparam int FRAME_BYTES = 130;
`else
    localparam int FRAME_BYTES = 129;
`endif
    localparam int FRAME_CYC   = FRAME_BYTES * BYTE_CYC;
    localparam int MAX_ERRORS  = 40;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] dbg_regs [0:31];
    logic        dump_req = 1'b0;
    logic        uart_tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 frame on the line (m_t cycles since first start bit), 2 done cycle.
    int          m_phase = 0;
    int          m_t     = 0;
    logic [31:0] m_word [0:31];
    logic        req_s;
    logic [2:0]  exp_out;
    int          cyc       = 0;
    int          start_cyc = 0;
    int          done_cyc  = 0;
    int          done_cnt  = 0;
    logic        busy_prev = 1'b0;

    logic [7:0]  rx_q [$];
    logic        rx_busy = 1'b0;
    int          rx_cnt  = 0;
    logic [7:0]  rx_byte = 8'h00;

    always #5 clk = ~clk;

    reg_dump_uart_tx #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .BAUD       (BAUD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .dbg_regs(dbg_regs),
        .dump_req(dump_req),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int k);
        logic [7:0] x;
        if (k == 0) return 8'hA5;
        if (k <= 128) return m_word[(k - 1) / 4][8 * ((k - 1) % 4) +: 8];
        x = 8'h00;
        for (int j = 1; j <= 128; j++) x = x ^ m_word[(j - 1) / 4][8 * ((j - 1) % 4) +: 8];
        return x;
    endfunction

    function automatic logic expected_line(input int t);
        int         b;
        logic [7:0] v;
        b = (t % BYTE_CYC) / CPB;
        v = frame_byte(t / BYTE_CYC);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return v[b - 1];
    endfunction

    function automatic logic [7:0] rx_at(input int k);
        if (k < rx_q.size()) return rx_q[k];
        return 8'hxx;
    endfunction

    // Model advance at the edge, then compare all three outputs once per cycle.
    always @(posedge clk) begin
        req_s = dump_req;
        if (!reset) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (req_s) begin
                    m_phase = 1;
                    m_t     = 0;
                end
                1: begin
                    m_t++;
                    if (m_t == FRAME_CYC) begin
                        m_phase = 2;
                    end else if ((m_t % BYTE_CYC == 0) && (m_t / BYTE_CYC <= 128) && ((m_t / BYTE_CYC - 1) % 4 == 0)) begin
                        m_word[(m_t / BYTE_CYC - 1) / 4] = dbg_regs[(m_t / BYTE_CYC - 1) / 4];
                    end
                end
                default: m_phase = 0;
            endcase
        end
        #1;
        cyc++;
        case (m_phase)
            1:       exp_out = {expected_line(m_t), 2'b10};
            2:       exp_out = 3'b101;
            default: exp_out = 3'b100;
        endcase
        check_output("line_busy_done", {29'd0, uart_tx, busy, done}, {29'd0, exp_out});
        if (busy && !busy_prev) start_cyc = cyc;
        busy_prev = busy;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (errors >= MAX_ERRORS) finish_sim();
    end

    // Independent receiver: samples mid-bit from the detected start edge.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (uart_tx == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
                rx_byte = 8'h00;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB == CPB / 2) && (rx_cnt / CPB >= 1) && (rx_cnt / CPB <= 8))
                rx_byte[rx_cnt / CPB - 1] = uart_tx;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                if (uart_tx == 1'b1) rx_q.push_back(rx_byte);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic pulse_req();
        @(negedge clk);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic apply_stimulus();
        // Reset and idle
        for (int i = 0; i < 32; i++) dbg_regs[i] = 32'h0;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_output("reset_state", {29'd0, uart_tx, busy, done}, 32'h4);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        check_output("idle_200", {29'd0, uart_tx, busy, done}, 32'h4);

        // Basic dump with ignored requests mid-frame and during the done cycle
        for (int i = 0; i < 32; i++) dbg_regs[i] = 32'h0101_0101 * 32'(i);
        rx_q.delete();
        done_cnt = 0;
        pulse_req();
        check_output("accept_busy", {31'd0, busy}, 32'd1);
        check_output("accept_start_bit", {31'd0, uart_tx}, 32'd0);
        repeat (1000) @(negedge clk);
        pulse_req();
        wait_done(FRAME_CYC + 100);
        dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        repeat (BYTE_CYC) @(negedge clk);
        check_output("no_restart_after_finish", {30'd0, uart_tx, busy}, 32'h2);
        check_output("frame_a_len", rx_q.size(), FRAME_BYTES);
        check_output("frame_a_done_pulses", done_cnt, 32'd1);
        check_output("frame_a_duration", done_cyc - start_cyc, FRAME_CYC);
        check_output("frame_a_sync", {24'd0, rx_at(0)}, 32'hA5);
        check_output("frame_a_x0_b3", {24'd0, rx_at(4)}, 32'h00);
        check_output("frame_a_x1_b0", {24'd0, rx_at(5)}, 32'h01);
        check_output("frame_a_x31_b3", {24'd0, rx_at(128)}, 32'h1F);
`ifdef DUMP_CHECKSUM_EN
        check_output("frame_a_chksum", {24'd0, rx_at(129)}, 32'h00);
`endif

        // New frame after done, aborted by reset during a data bit of x10
        rx_q.delete();
        pulse_req();
        check_output("restart_busy", {31'd0, busy}, 32'd1);
        repeat (41 * BYTE_CYC + 3 * CPB + 5) @(negedge clk);
        check_output("x10_bit2_low", {31'd0, uart_tx}, 32'd0);
        #2 reset = 1'b0;
        #1;
        check_output("async_abort", {29'd0, uart_tx, busy, done}, 32'h4);
        check_output("abort_rx_len", rx_q.size(), 32'd41);
        check_output("abort_x9_b3", {24'd0, rx_at(40)}, 32'h09);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Full frame after abort, with x5 changed while its byte 1 is on the line
        dbg_regs[5] = 32'h1122_3344;
        rx_q.delete();
        done_cnt = 0;
        pulse_req();
        repeat (22 * BYTE_CYC + 40) @(negedge clk);
        dbg_regs[5] = 32'hAABB_CCDD;
        wait_done(FRAME_CYC);
        @(negedge clk);
        check_output("frame_d_len", rx_q.size(), FRAME_BYTES);
        check_output("frame_d_duration", done_cyc - start_cyc, FRAME_CYC);
        check_output("frame_d_sync", {24'd0, rx_at(0)}, 32'hA5);
        check_output("frame_d_x5", {rx_at(24), rx_at(23), rx_at(22), rx_at(21)}, 32'h1122_3344);
        check_output("frame_d_x6_b0", {24'd0, rx_at(25)}, 32'h06);
`ifdef DUMP_CHECKSUM_EN
        check_output("frame_d_chksum", {24'd0, rx_at(129)}, 32'h44);

        for (int i = 0; i < 32; i++) dbg_regs[i] = 32'h0;
        dbg_regs[1] = 32'h0000_00FF;
        rx_q.delete();
        pulse_req();
        wait_done(FRAME_CYC + 10);
        @(negedge clk);
        check_output("frame_e_len", rx_q.size(), 32'd130);
        check_output("frame_e_chksum", {24'd0, rx_at(129)}, 32'hFF);
`endif
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        finish_sim();
    end

    initial begin
        apply_stimulus();
        finish_sim();
    end

endmodule
